// File: rtl/spi_burst_controller.sv
// spi_burst_controller
//   Decodes SPI command words into single or burst register-bus transfers.
//   A command word carries write/read, burst/single and a start address.
//   Reads fetch bus data into the next SPI transmit word; writes latch each
//   received data word and issue a one-cycle write strobe.
//
// Ports
//   i_clk            sole clock, rising edge
//   i_rst            synchronous active-high reset
//   i_spi_data_rx    word received from the SPI slave, valid with i_spi_ready
//   i_spi_ready      one-cycle pulse per completed SPI word
//   i_spi_busy       high while the SPI frame (chip select) is active
//   o_spi_data_tx    word the SPI slave shifts out next
//   i_data_read_bus  combinational read data for o_addr_bus
//   o_addr_bus       bus address
//   o_data_write_bus bus write data
//   o_wr_enable_bus  one-cycle write strobe
//   o_rd_enable_bus  one-cycle read strobe
//   o_overrun        sticky: a word arrived when it could not be accepted
`timescale 1ns / 1ps

module spi_burst_controller #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned MAX_ADDR   = 2 ** ADDR_WIDTH - 1,
    parameter logic [DATA_WIDTH-1:0] ACK_WORD  = DATA_WIDTH'(8'h55),
    parameter logic [DATA_WIDTH-1:0] NACK_WORD = DATA_WIDTH'(8'hEE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_spi_data_rx,
    input  logic                  i_spi_ready,
    input  logic                  i_spi_busy,
    output logic [DATA_WIDTH-1:0] o_spi_data_tx,
    input  logic [DATA_WIDTH-1:0] i_data_read_bus,
    output logic [ADDR_WIDTH-1:0] o_addr_bus,
    output logic [DATA_WIDTH-1:0] o_data_write_bus,
    output logic                  o_wr_enable_bus,
    output logic                  o_rd_enable_bus,
    output logic                  o_overrun
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCmd      = 3'd1,
        StRdFetch  = 3'd2,
        StRdWait   = 3'd3,
        StWrWait   = 3'd4,
        StWrStrobe = 3'd5
    } state_e;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_tx;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic                  r_overrun;
    logic                  r_write;
    logic                  r_burst;
    // Set by reset; blocks new commands until the interrupted frame has ended.
    logic                  r_wait_idle;

    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_addr_valid;
    logic                  w_inc_valid;

    // Increment wraps modulo 2**ADDR_WIDTH; each word is checked separately.
    assign w_addr_inc   = r_addr + ADDR_WIDTH'(1);
    assign w_addr_valid = (32'(r_addr) <= MAX_ADDR);
    assign w_inc_valid  = (32'(w_addr_inc) <= MAX_ADDR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_addr      <= '1;
            r_wdata     <= '0;
            r_tx        <= ACK_WORD;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_overrun   <= 1'b0;
            r_write     <= 1'b0;
            r_burst     <= 1'b0;
            r_wait_idle <= 1'b1;
        end else begin
            // Strobes are single-cycle: raised only on entry to a strobe state.
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            if (!i_spi_busy) begin
                r_wait_idle <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    r_tx <= ACK_WORD;
                    if (i_spi_ready && !r_wait_idle) begin
                        r_addr    <= i_spi_data_rx[ADDR_WIDTH-1:0];
                        r_write   <= i_spi_data_rx[DATA_WIDTH-1];
                        r_burst   <= i_spi_data_rx[DATA_WIDTH-2];
                        r_overrun <= 1'b0;
                        r_state   <= StCmd;
                    end
                end

                StCmd: begin
                    if (i_spi_ready) begin
                        r_overrun <= 1'b1;
                    end
                    if (!i_spi_busy) begin
                        r_state <= StIdle;
                    end else if (r_write) begin
                        r_tx    <= w_addr_valid ? ACK_WORD : NACK_WORD;
                        r_state <= StWrWait;
                    end else begin
                        r_rd_en <= w_addr_valid;
                        r_state <= StRdFetch;
                    end
                end

                StRdFetch: begin
                    if (i_spi_ready) begin
                        r_overrun <= 1'b1;
                    end
                    if (!i_spi_busy) begin
                        r_tx    <= ACK_WORD;
                        r_state <= StIdle;
                    end else begin
                        r_tx    <= w_addr_valid ? i_data_read_bus : NACK_WORD;
                        r_state <= StRdWait;
                    end
                end

                StRdWait: begin
                    if (!i_spi_busy) begin
                        r_tx    <= ACK_WORD;
                        r_state <= StIdle;
                    end else if (i_spi_ready) begin
                        if (r_burst) begin
                            r_addr  <= w_addr_inc;
                            r_rd_en <= w_inc_valid;
                            r_state <= StRdFetch;
                        end else begin
                            r_tx    <= ACK_WORD;
                            r_state <= StIdle;
                        end
                    end
                end

                StWrWait: begin
                    if (!i_spi_busy) begin
                        r_tx    <= ACK_WORD;
                        r_state <= StIdle;
                    end else if (i_spi_ready) begin
                        r_wdata <= i_spi_data_rx;
                        r_wr_en <= w_addr_valid;
                        r_tx    <= ACK_WORD;
                        r_state <= StWrStrobe;
                    end
                end

                StWrStrobe: begin
                    if (i_spi_ready) begin
                        r_overrun <= 1'b1;
                    end
                    // The strobe is already out; a dropped frame just ends here.
                    if (i_spi_busy && r_burst) begin
                        r_addr  <= w_addr_inc;
                        r_tx    <= w_inc_valid ? ACK_WORD : NACK_WORD;
                        r_state <= StWrWait;
                    end else begin
                        r_tx    <= ACK_WORD;
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_tx    <= ACK_WORD;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_spi_data_tx    = r_tx;
    assign o_addr_bus       = r_addr;
    assign o_data_write_bus = r_wdata;
    assign o_wr_enable_bus  = r_wr_en;
    assign o_rd_enable_bus  = r_rd_en;
    assign o_overrun        = r_overrun;

endmodule

// File: tb/tb_spi_burst_controller.sv
// tb_spi_burst_controller
//   Directed bench for spi_burst_controller. Two instances share the SPI
//   stimulus: dut0 uses default parameters, dut1 uses MAX_ADDR = 40.
`timescale 1ns / 1ps

module tb_spi_burst_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx;
    logic       ready;
    logic       busy;

    logic [7:0] tx0, tx1, rdat0, rdat1, wdata0, wdata1;
    logic [5:0] addr0, addr1;
    logic       wr0, wr1, rde0, rde1, ov0, ov1;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt0 = 0, wr_cnt1 = 0, rd_cnt0 = 0, rd_cnt1 = 0;
    int s_wr0, s_wr1, s_rd0, s_rd1;

    always #5 clk = ~clk;

    // Bus models: dut0 returns A7 at address 10, dut1 returns C0 | address.
    assign rdat0 = (addr0 == 6'd10) ? 8'hA7 : 8'h00;
    assign rdat1 = 8'hC0 | {2'b00, addr1};

    always @(posedge clk) begin
        if (wr0)  wr_cnt0 <= wr_cnt0 + 1;
        if (wr1)  wr_cnt1 <= wr_cnt1 + 1;
        if (rde0) rd_cnt0 <= rd_cnt0 + 1;
        if (rde1) rd_cnt1 <= rd_cnt1 + 1;
    end

    spi_burst_controller dut0 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_spi_data_rx   (rx),
        .i_spi_ready     (ready),
        .i_spi_busy      (busy),
        .o_spi_data_tx   (tx0),
        .i_data_read_bus (rdat0),
        .o_addr_bus      (addr0),
        .o_data_write_bus(wdata0),
        .o_wr_enable_bus (wr0),
        .o_rd_enable_bus (rde0),
        .o_overrun       (ov0)
    );

    spi_burst_controller #(.MAX_ADDR(40)) dut1 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_spi_data_rx   (rx),
        .i_spi_ready     (ready),
        .i_spi_busy      (busy),
        .o_spi_data_tx   (tx1),
        .i_data_read_bus (rdat1),
        .o_addr_bus      (addr1),
        .o_data_write_bus(wdata1),
        .o_wr_enable_bus (wr1),
        .o_rd_enable_bus (rde1),
        .o_overrun       (ov1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        rx    = w;
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_wr0 = wr_cnt0;
        s_wr1 = wr_cnt1;
        s_rd0 = rd_cnt0;
        s_rd1 = rd_cnt1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        busy  = 1'b0;
        ready = 1'b0;
        rx    = 8'h00;
        tick();
        tick();
        check("rst_addr", 32'(addr0), 32'h3F);
        check("rst_wdata", 32'(wdata0), 32'h00);
        check("rst_wr", 32'(wr0), 32'h0);
        check("rst_rd", 32'(rde0), 32'h0);
        check("rst_tx", 32'(tx0), 32'h55);
        check("rst_ov", 32'(ov0), 32'h0);
        rst = 1'b0;
        tick();

        // Single write: cmd 85, data 3C.
        snap();
        busy = 1'b1;
        tick();
        send(8'h85);
        tick();
        check("sw_tx_wait", 32'(tx0), 32'h55);
        send(8'h3C);
        check("sw_strobe", 32'(wr0), 32'h1);
        check("sw_addr", 32'(addr0), 32'h05);
        check("sw_data", 32'(wdata0), 32'h3C);
        tick();
        check("sw_strobe_end", 32'(wr0), 32'h0);
        check("sw_tx_idle", 32'(tx0), 32'h55);
        busy = 1'b0;
        tick();
        check("sw_count", 32'(wr_cnt0 - s_wr0), 32'd1);

        // Single read: cmd 0A, bus returns A7 at address 10.
        snap();
        busy = 1'b1;
        send(8'h0A);
        check("sr_no_early_rd", 32'(rde0), 32'h0);
        tick();
        check("sr_strobe", 32'(rde0), 32'h1);
        check("sr_addr", 32'(addr0), 32'h0A);
        tick();
        check("sr_strobe_end", 32'(rde0), 32'h0);
        check("sr_tx", 32'(tx0), 32'hA7);
        tick();
        check("sr_tx_hold", 32'(tx0), 32'hA7);
        send(8'h00);
        check("sr_tx_after", 32'(tx0), 32'h55);
        check("sr_count", 32'(rd_cnt0 - s_rd0), 32'd1);
        busy = 1'b0;
        tick();

        // Burst write from 62 with wrap: data 11, 22, 33.
        snap();
        busy = 1'b1;
        send(8'hFE);
        tick();
        check("bw_tx0", 32'(tx0), 32'h55);
        check("bw_tx1_nack", 32'(tx1), 32'hEE);
        send(8'h11);
        check("bw_s0", 32'(wr0), 32'h1);
        check("bw_a0", 32'(addr0), 32'd62);
        check("bw_d0", 32'(wdata0), 32'h11);
        tick();
        send(8'h22);
        check("bw_s1", 32'(wr0), 32'h1);
        check("bw_a1", 32'(addr0), 32'd63);
        check("bw_d1", 32'(wdata0), 32'h22);
        tick();
        check("bw_tx1_ack_wrap", 32'(tx1), 32'h55);
        send(8'h33);
        check("bw_s2", 32'(wr0), 32'h1);
        check("bw_a2", 32'(addr0), 32'd0);
        check("bw_d2", 32'(wdata0), 32'h33);
        tick();
        busy = 1'b0;
        tick();
        check("bw_count0", 32'(wr_cnt0 - s_wr0), 32'd3);
        check("bw_count1", 32'(wr_cnt1 - s_wr1), 32'd1);

        // Burst read from 39 on dut1 (MAX_ADDR 40).
        snap();
        busy = 1'b1;
        send(8'h67);
        tick();
        check("br_s39", 32'(rde1), 32'h1);
        check("br_a39", 32'(addr1), 32'd39);
        tick();
        check("br_tx39", 32'(tx1), 32'hE7);
        send(8'h00);
        check("br_s40", 32'(rde1), 32'h1);
        check("br_a40", 32'(addr1), 32'd40);
        tick();
        check("br_tx40", 32'(tx1), 32'hE8);
        send(8'h00);
        check("br_s41_none", 32'(rde1), 32'h0);
        check("br_a41", 32'(addr1), 32'd41);
        check("br_s41_dut0", 32'(rde0), 32'h1);
        tick();
        check("br_tx41_nack", 32'(tx1), 32'hEE);
        check("br_tx41_dut0", 32'(tx0), 32'h00);
        busy = 1'b0;
        tick();
        check("br_tx_idle", 32'(tx1), 32'h55);
        check("br_count1", 32'(rd_cnt1 - s_rd1), 32'd2);
        check("br_count0", 32'(rd_cnt0 - s_rd0), 32'd3);

        // Overrun in CMD, then busy drop in WR_WAIT (cmd C3).
        snap();
        busy = 1'b1;
        send(8'hC3);
        send(8'h99);
        check("ov_set", 32'(ov0), 32'h1);
        busy = 1'b0;
        tick();
        tick();
        check("ov_sticky", 32'(ov0), 32'h1);
        check("drop_no_strobe", 32'(wr_cnt0 - s_wr0), 32'd0);
        check("drop_tx", 32'(tx0), 32'h55);
        busy = 1'b1;
        send(8'h05);
        check("ov_cleared", 32'(ov0), 32'h0);
        tick();
        tick();
        send(8'h00);
        busy = 1'b0;
        tick();

        // Reset in RD_WAIT.
        snap();
        busy = 1'b1;
        send(8'h0A);
        send(8'h77);
        tick();
        check("pre_rst_tx", 32'(tx0), 32'hA7);
        check("pre_rst_ov", 32'(ov0), 32'h1);
        rst = 1'b1;
        tick();
        check("mr_addr", 32'(addr0), 32'h3F);
        check("mr_wdata", 32'(wdata0), 32'h00);
        check("mr_wr", 32'(wr0), 32'h0);
        check("mr_rd", 32'(rde0), 32'h0);
        check("mr_tx", 32'(tx0), 32'h55);
        check("mr_ov", 32'(ov0), 32'h0);
        rst = 1'b0;
        // Rest of the interrupted frame must be ignored.
        send(8'h85);
        tick();
        send(8'h3C);
        tick();
        tick();
        check("mr_ignored_wr", 32'(wr_cnt0 - s_wr0), 32'd0);
        check("mr_ignored_addr", 32'(addr0), 32'h3F);
        busy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
